// File: rtl/tap_ir_dr_chain.sv
// JTAG instruction/data register chain driven by the TAP controller's state code.
// Holds IR, BYPASS, IDCODE and USER registers and shifts TDI toward TDO.
module tap_ir_dr_chain #(
  parameter int              IR_W       = 4,
  parameter int              DR_W       = 8,
  parameter logic [31:0]     IDCODE_VAL = 32'h1000_0A5F,
  parameter logic [IR_W-1:0] INS_IDCODE = IR_W'(1),
  parameter logic [IR_W-1:0] INS_USER   = IR_W'(2)
) (
  input  logic            GCLK,
  input  logic            TRST_n,
  input  logic [3:0]      state_obs,
  input  logic            TDI,
  output logic            TDO,
  output logic            TDO_en,
  output logic [IR_W-1:0] ir_q,
  output logic [DR_W-1:0] user_q,
  output logic            user_upd
);

  typedef enum logic [3:0] {
    ST_EX2_DR = 4'h0, ST_EX1_DR = 4'h1, ST_SH_DR  = 4'h2, ST_PS_DR  = 4'h3,
    ST_SEL_IR = 4'h4, ST_UPD_DR = 4'h5, ST_CAP_DR = 4'h6, ST_SEL_DR = 4'h7,
    ST_EX2_IR = 4'h8, ST_EX1_IR = 4'h9, ST_SH_IR  = 4'hA, ST_PS_IR  = 4'hB,
    ST_RTI    = 4'hC, ST_UPD_IR = 4'hD, ST_CAP_IR = 4'hE, ST_TLR    = 4'hF
  } tap_state_e;

  tap_state_e      w_state;
  logic            w_sel_id;
  logic            w_sel_user;
  logic            w_dr_lsb;

  logic [IR_W-1:0] r_ir_sr;
  logic [IR_W-1:0] r_ir_q;
  logic [31:0]     r_id_sr;
  logic [DR_W-1:0] r_user_sr;
  logic [DR_W-1:0] r_user_q;
  logic            r_bypass;
  logic            r_tdo;
  logic            r_tdo_en;
  logic            r_user_upd;

  assign w_state    = tap_state_e'(state_obs);
  assign w_sel_id   = (r_ir_q == INS_IDCODE);
  assign w_sel_user = !w_sel_id && (r_ir_q == INS_USER);

  always_comb begin
    // NOTE: defaulting every combinational output first keeps this a pure mux (no latch).
    w_dr_lsb = r_bypass;
    if (w_sel_id)        w_dr_lsb = r_id_sr[0];
    else if (w_sel_user) w_dr_lsb = r_user_sr[0];
  end

  // Instruction register path.
  // NOTE: every register, including the shift registers, is cleared by the async reset
  // so a reset mid-scan discards partial contents immediately.
  always_ff @(posedge GCLK or negedge TRST_n) begin
    if (!TRST_n) begin
      r_ir_sr <= '0;
      r_ir_q  <= INS_IDCODE;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      unique case (w_state)
        ST_TLR: begin
          r_ir_q  <= INS_IDCODE;
          r_ir_sr <= '0;
        end
        ST_CAP_IR: r_ir_sr <= IR_W'(2'b01);
        ST_SH_IR:  r_ir_sr <= {TDI, r_ir_sr[IR_W-1:1]};
        ST_UPD_IR: r_ir_q  <= r_ir_sr;
        default: ;
      endcase
    end
  end

  // Data register path: only the register selected by the current instruction moves.
  always_ff @(posedge GCLK or negedge TRST_n) begin
    if (!TRST_n) begin
      r_id_sr    <= '0;
      r_user_sr  <= '0;
      r_user_q   <= '0;
      r_bypass   <= 1'b0;
      r_user_upd <= 1'b0;
    end else begin
      r_user_upd <= 1'b0;
      unique case (w_state)
        ST_CAP_DR: begin
          if (w_sel_id)        r_id_sr   <= IDCODE_VAL;
          else if (w_sel_user) r_user_sr <= r_user_q;
          else                 r_bypass  <= 1'b0;
        end
        ST_SH_DR: begin
          if (w_sel_id)        r_id_sr   <= {TDI, r_id_sr[31:1]};
          else if (w_sel_user) r_user_sr <= {TDI, r_user_sr[DR_W-1:1]};
          else                 r_bypass  <= TDI;
        end
        ST_UPD_DR: begin
          if (w_sel_user) begin
            r_user_q   <= r_user_sr;
            r_user_upd <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Serial output: TDO holds its last bit outside the shift states.
  always_ff @(posedge GCLK or negedge TRST_n) begin
    if (!TRST_n) begin
      r_tdo    <= 1'b0;
      r_tdo_en <= 1'b0;
    end else begin
      r_tdo_en <= (w_state == ST_SH_IR) || (w_state == ST_SH_DR);
      if (w_state == ST_SH_IR)      r_tdo <= r_ir_sr[0];
      else if (w_state == ST_SH_DR) r_tdo <= w_dr_lsb;
    end
  end

  assign TDO      = r_tdo;
  assign TDO_en   = r_tdo_en;
  assign ir_q     = r_ir_q;
  assign user_q   = r_user_q;
  assign user_upd = r_user_upd;

endmodule

// File: tb/tb_tap_ir_dr_chain.sv
// Bench for tap_ir_dr_chain: directed scans plus random state-code traffic, checked
// against a queue-based model of the scan registers.
module tb_tap_ir_dr_chain;

  localparam logic [31:0] ID_VAL = 32'h1000_0A5F;

  logic       GCLK = 1'b0;
  logic       TRST_n;
  logic [3:0] state_obs;
  logic       TDI;
  logic       TDO;
  logic       TDO_en;
  logic [3:0] ir_q;
  logic [7:0] user_q;
  logic       user_upd;

  always #5 GCLK = ~GCLK;

  tap_ir_dr_chain dut (
    .GCLK      (GCLK),
    .TRST_n    (TRST_n),
    .state_obs (state_obs),
    .TDI       (TDI),
    .TDO       (TDO),
    .TDO_en    (TDO_en),
    .ir_q      (ir_q),
    .user_q    (user_q),
    .user_upd  (user_upd)
  );

  int n_cmp   = 0;
  int n_err   = 0;
  int en_seen = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: each scan register is a bit FIFO (front = bit shifted out next).
  logic [3:0] m_ir;
  logic [7:0] m_user;
  logic       m_tdo, m_en, m_upd;
  bit         q_ir[$];
  bit         q_id[$];
  bit         q_us[$];
  bit         q_by[$];

  function automatic int sel_dr();
    if (m_ir == 4'h1) return 0;
    if (m_ir == 4'h2) return 1;
    return 2;
  endfunction

  task automatic model_reset();
    m_ir = 4'h1; m_user = '0; m_tdo = 1'b0; m_en = 1'b0; m_upd = 1'b0;
    q_ir.delete(); q_id.delete(); q_us.delete(); q_by.delete();
    for (int i = 0; i < 4; i++)  q_ir.push_back(1'b0);
    for (int i = 0; i < 32; i++) q_id.push_back(1'b0);
    for (int i = 0; i < 8; i++)  q_us.push_back(1'b0);
    q_by.push_back(1'b0);
  endtask

  task automatic model_edge(input logic [3:0] code, input logic tdi);
    m_upd = 1'b0;
    m_en  = (code == 4'hA) || (code == 4'h2);
    case (code)
      4'hF: begin
        m_ir = 4'h1;
        q_ir.delete();
        for (int i = 0; i < 4; i++) q_ir.push_back(1'b0);
      end
      4'hE: begin
        q_ir.delete();
        for (int i = 0; i < 4; i++) q_ir.push_back(i == 0);
      end
      4'hA: begin
        m_tdo = q_ir.pop_front();
        q_ir.push_back(tdi);
      end
      4'hD: for (int i = 0; i < 4; i++) m_ir[i] = q_ir[i];
      4'h6: begin
        case (sel_dr())
          0: begin q_id.delete(); for (int i = 0; i < 32; i++) q_id.push_back(ID_VAL[i]); end
          1: begin q_us.delete(); for (int i = 0; i < 8; i++) q_us.push_back(m_user[i]); end
          default: begin q_by.delete(); q_by.push_back(1'b0); end
        endcase
      end
      4'h2: begin
        case (sel_dr())
          0: begin m_tdo = q_id.pop_front(); q_id.push_back(tdi); end
          1: begin m_tdo = q_us.pop_front(); q_us.push_back(tdi); end
          default: begin m_tdo = q_by.pop_front(); q_by.push_back(tdi); end
        endcase
      end
      4'h5: begin
        if (sel_dr() == 1) begin
          for (int i = 0; i < 8; i++) m_user[i] = q_us[i];
          m_upd = 1'b1;
        end
      end
      default: ;
    endcase
  endtask

  task automatic cmp_outs();
    check("tdo",      TDO,      m_tdo);
    check("tdo_en",   TDO_en,   m_en);
    check("ir_q",     ir_q,     m_ir);
    check("user_q",   user_q,   m_user);
    check("user_upd", user_upd, m_upd);
  endtask

  // Called at a falling edge: drive, clock, compare on the next falling edge.
  task automatic step(input logic [3:0] code, input logic tdi, output logic tdo_obs);
    state_obs = code;
    TDI       = tdi;
    @(posedge GCLK);
    model_edge(code, tdi);
    @(negedge GCLK);
    cmp_outs();
    if (TDO_en === 1'b1) en_seen++;
    tdo_obs = TDO;
  endtask

  task automatic ir_scan(input logic [3:0] v, output logic [3:0] dout);
    logic b;
    step(4'hE, 1'b0, b);
    for (int i = 0; i < 4; i++) begin
      step(4'hA, v[i], b);
      dout[i] = b;
    end
    step(4'h9, 1'b0, b);
    step(4'hD, 1'b0, b);
  endtask

  task automatic dr_scan(input int n, input logic [31:0] din, output logic [31:0] dout);
    logic b;
    dout = '0;
    step(4'h6, 1'b0, b);
    for (int i = 0; i < n; i++) begin
      step(4'h2, din[i % 32], b);
      if (i < 32) dout[i] = b;
    end
    step(4'h1, 1'b0, b);
    step(4'h5, 1'b0, b);
  endtask

  task automatic pulse_reset();
    #2 TRST_n = 1'b0;
    #1 model_reset();
    cmp_outs();
    @(negedge GCLK);
    TRST_n = 1'b1;
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0]  iro;
    logic [31:0] dout;
    logic [31:0] din;
    logic        b;

    TRST_n = 1'b0; state_obs = 4'hC; TDI = 1'b0;
    model_reset();
    @(negedge GCLK);
    @(negedge GCLK);
    cmp_outs();
    TRST_n = 1'b1;
    step(4'hC, 1'b0, b);

    // 1: IDCODE scan straight after reset.
    en_seen = 0;
    dr_scan(32, $urandom, dout);
    check("t1_idcode", dout, ID_VAL);
    check("t1_en_cycles", en_seen, 32);

    // 2: IR all-ones -> BYPASS.
    ir_scan(4'hF, iro);
    check("t2_ir_tdo", iro, 4'b0001);
    check("t2_ir_q", ir_q, 4'hF);
    dr_scan(2, 32'h1, dout);
    check("t2_bypass", dout, 32'h2);

    // 3: USER load and rescan.
    ir_scan(4'h2, iro);
    dr_scan(8, 32'hA5, dout);
    check("t3_user_q", user_q, 8'hA5);
    check("t3_upd_hi", user_upd, 1'b1);
    step(4'hC, 1'b0, b);
    check("t3_upd_lo", user_upd, 1'b0);
    dr_scan(8, 32'h3C, dout);
    check("t3_rescan_out", dout, 32'hA5);
    check("t3_user_q2", user_q, 8'h3C);

    // 4: undefined opcode behaves as BYPASS.
    ir_scan(4'h7, iro);
    din = $urandom;
    dr_scan(8, din, dout);
    check("t4_bypass", dout[7:0], {din[6:0], 1'b0});
    check("t4_user_hold", user_q, 8'h3C);

    // 5: reset in the middle of a USER shift.
    ir_scan(4'h2, iro);
    step(4'h6, 1'b0, b);
    for (int i = 0; i < 3; i++) step(4'h2, 1'b1, b);
    pulse_reset();
    check("t5_ir_q", ir_q, 4'h1);
    check("t5_user_q", user_q, 8'h00);
    check("t5_tdo", TDO, 1'b0);
    step(4'hC, 1'b0, b);
    dr_scan(32, $urandom, dout);
    check("t5_idcode", dout, ID_VAL);

    // 6: one TLR cycle restores IDCODE instruction without touching USER.
    ir_scan(4'h2, iro);
    step(4'hF, 1'b0, b);
    check("t6_ir_q", ir_q, 4'h1);
    check("t6_user_q", user_q, 8'h00);
    check("t6_upd", user_upd, 1'b0);

    // Random traffic.
    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 3))
        0:       ir_scan(4'h1, iro);
        1, 2:    ir_scan(4'h2, iro);
        default: ir_scan(4'($urandom), iro);
      endcase
      dr_scan($urandom_range(1, 40), $urandom, dout);
      for (int k = 0; k < 8; k++) begin
        if ($urandom_range(0, 3) == 0) step(4'h2, 1'($urandom), b);
        else                           step(4'($urandom_range(0, 15)), 1'($urandom), b);
      end
      if (it % 13 == 5) pulse_reset();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
